// File: rtl/vga_timing_gen_if.sv
// Signal bundle for vga_timing_gen: requested timing, pixel source and video outputs.
// The master side supplies timing and pixels; the slave side is the timing generator.
interface vga_timing_gen_if #(
  parameter int CNT_W = 11
);
  logic [CNT_W-1:0] h_sync_w;
  logic [CNT_W-1:0] h_bp_w;
  logic [CNT_W-1:0] h_act_w;
  logic [CNT_W-1:0] h_fp_w;
  logic [CNT_W-1:0] v_sync_w;
  logic [CNT_W-1:0] v_bp_w;
  logic [CNT_W-1:0] v_act_w;
  logic [CNT_W-1:0] v_fp_w;
  logic [11:0]      pixel_in;
  logic [1:0]       pattern_sel;

  logic             hsync;
  logic             vsync;
  logic             de;
  logic [CNT_W-1:0] x_pos;
  logic [CNT_W-1:0] y_pos;
  logic [11:0]      rgb;
  logic             line_start;
  logic             frame_start;

  modport master (
    output h_sync_w, h_bp_w, h_act_w, h_fp_w,
    output v_sync_w, v_bp_w, v_act_w, v_fp_w,
    output pixel_in, pattern_sel,
    input  hsync, vsync, de, x_pos, y_pos, rgb, line_start, frame_start
  );

  modport slave (
    input  h_sync_w, h_bp_w, h_act_w, h_fp_w,
    input  v_sync_w, v_bp_w, v_act_w, v_fp_w,
    input  pixel_in, pattern_sel,
    output hsync, vsync, de, x_pos, y_pos, rgb, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator with registered sync, data enable, coordinates,
// colour and line/frame start pulses. Timing is taken from shadow registers that
// only reload at the frame boundary (or on the first clock after reset).
// Optional build macro TEST_PATTERN_EN adds built-in colour patterns on pattern_sel;
// without it the colour is always pixel_in gated by de.
module vga_timing_gen #(
  parameter int CNT_W     = 11,
  parameter bit SYNC_POL  = 1'b0,
  parameter int BAR_SHIFT = 6,
  parameter int H_SYNC_D  = 96,
  parameter int H_BP_D    = 48,
  parameter int H_ACT_D   = 640,
  parameter int H_FP_D    = 16,
  parameter int V_SYNC_D  = 2,
  parameter int V_BP_D    = 33,
  parameter int V_ACT_D   = 480,
  parameter int V_FP_D    = 10
) (
  input  logic            clk_in,
  input  logic            rst_in,
  vga_timing_gen_if.slave vif
);

  localparam int CW = CNT_W + 2;

  logic [CNT_W-1:0] h_sync_s, h_bp_s, h_act_s, h_fp_s;
  logic [CNT_W-1:0] v_sync_s, v_bp_s, v_act_s, v_fp_s;
  logic [CW-1:0]    hc, vc, hc_next, vc_next;
  logic             run_q;

  logic [CW-1:0]    htot, vtot, h_blank, v_blank, h_act_end, v_act_end;
  logic             h_valid, v_valid, timing_ok, h_last, v_last, load_shadow;

  logic             live, active, in_h_sync, in_v_sync, h_act, v_act;
  logic             hsync_next, vsync_next, de_next, line_next, frame_next;
  logic [CNT_W-1:0] x_next, y_next;
  logic [11:0]      rgb_next;

  logic             hsync_q, vsync_q, de_q, line_q, frame_q;
  logic [CNT_W-1:0] x_q, y_q;
  logic [11:0]      rgb_q;

  // Frame geometry derived from the shadow fields, widened so sums cannot overflow.
  assign htot      = CW'(h_sync_s) + CW'(h_bp_s) + CW'(h_act_s) + CW'(h_fp_s);
  assign vtot      = CW'(v_sync_s) + CW'(v_bp_s) + CW'(v_act_s) + CW'(v_fp_s);
  assign h_blank   = CW'(h_sync_s) + CW'(h_bp_s);
  assign v_blank   = CW'(v_sync_s) + CW'(v_bp_s);
  assign h_act_end = h_blank + CW'(h_act_s);
  assign v_act_end = v_blank + CW'(v_act_s);

  // A degenerate geometry in either direction idles the whole generator.
  assign h_valid   = (h_act_s != '0) && (htot >= CW'(2));
  assign v_valid   = (v_act_s != '0) && (vtot >= CW'(2));
  assign timing_ok = h_valid && v_valid;

  // >= so that a counter left beyond a shrunken total still wraps cleanly.
  assign h_last = hc >= (htot - CW'(1));
  assign v_last = vc >= (vtot - CW'(1));

  // While idle the shadows reload every clock, so a valid request takes effect at once.
  assign load_shadow = !run_q || !timing_ok || (h_last && v_last);

  // Shadow timing registers: reset to the build-time mode, reload at frame end.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      h_sync_s <= CNT_W'(H_SYNC_D);
      h_bp_s   <= CNT_W'(H_BP_D);
      h_act_s  <= CNT_W'(H_ACT_D);
      h_fp_s   <= CNT_W'(H_FP_D);
      v_sync_s <= CNT_W'(V_SYNC_D);
      v_bp_s   <= CNT_W'(V_BP_D);
      v_act_s  <= CNT_W'(V_ACT_D);
      v_fp_s   <= CNT_W'(V_FP_D);
    end else if (load_shadow) begin
      h_sync_s <= vif.h_sync_w;
      h_bp_s   <= vif.h_bp_w;
      h_act_s  <= vif.h_act_w;
      h_fp_s   <= vif.h_fp_w;
      v_sync_s <= vif.v_sync_w;
      v_bp_s   <= vif.v_bp_w;
      v_act_s  <= vif.v_act_w;
      v_fp_s   <= vif.v_fp_w;
    end
  end

  // First clock after reset only primes the shadows; counting starts on the next one.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Next-count logic: horizontal wraps at the line end, vertical advances on that wrap.
  always_comb begin
    hc_next = hc;
    vc_next = vc;
    if (!run_q || !timing_ok) begin
      hc_next = '0;
      vc_next = '0;
    end else if (h_last) begin
      hc_next = '0;
      vc_next = v_last ? '0 : vc + CW'(1);
    end else begin
      hc_next = hc + CW'(1);
    end
  end

  // Pixel and line counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= hc_next;
      vc <= vc_next;
    end
  end

  // Decode the current counter state into the values the output registers will take.
  always_comb begin
    live       = run_q && timing_ok;
    in_h_sync  = hc < CW'(h_sync_s);
    in_v_sync  = vc < CW'(v_sync_s);
    h_act      = (hc >= h_blank) && (hc < h_act_end);
    v_act      = (vc >= v_blank) && (vc < v_act_end);
    active     = live && h_act && v_act;
    hsync_next = (live && in_h_sync) ? SYNC_POL : ~SYNC_POL;
    vsync_next = (live && in_v_sync) ? SYNC_POL : ~SYNC_POL;
    de_next    = active;
    x_next     = active ? CNT_W'(hc - h_blank) : '0;
    y_next     = active ? CNT_W'(vc - v_blank) : '0;
    line_next  = live && (hc == '0);
    frame_next = line_next && (vc == '0);
  end

`ifdef TEST_PATTERN_EN
  logic [2:0] bar_idx;

  // Colour source selection: external pixel, solid red, eight bars or checkerboard.
  always_comb begin
    bar_idx  = x_next[BAR_SHIFT+2:BAR_SHIFT];
    rgb_next = vif.pixel_in;
    case (vif.pattern_sel)
      2'd0: rgb_next = vif.pixel_in;
      2'd1: rgb_next = 12'hF00;
      2'd2: begin
        case (bar_idx)
          3'd0:    rgb_next = 12'hFFF;
          3'd1:    rgb_next = 12'hFF0;
          3'd2:    rgb_next = 12'h0FF;
          3'd3:    rgb_next = 12'h0F0;
          3'd4:    rgb_next = 12'hF0F;
          3'd5:    rgb_next = 12'hF00;
          3'd6:    rgb_next = 12'h00F;
          default: rgb_next = 12'h000;
        endcase
      end
      default: rgb_next = (x_next[4] ^ y_next[4]) ? 12'hFFF : 12'h000;
    endcase
    if (!active) rgb_next = 12'h000;
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = ^vif.pattern_sel;

  // Colour is the external pixel, blanked outside the active area.
  always_comb begin
    rgb_next = active ? vif.pixel_in : 12'h000;
  end
`endif

  // Output registers: everything leaves one clock after the counter state it describes.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= 12'h000;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      hsync_q <= hsync_next;
      vsync_q <= vsync_next;
      de_q    <= de_next;
      x_q     <= x_next;
      y_q     <= y_next;
      rgb_q   <= rgb_next;
      line_q  <= line_next;
      frame_q <= frame_next;
    end
  end

  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.de          = de_q;
  assign vif.x_pos       = x_q;
  assign vif.y_pos       = y_q;
  assign vif.rgb         = rgb_q;
  assign vif.line_start  = line_q;
  assign vif.frame_start = frame_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with the ports defined as follows.
REQ-002 Parameter CNT_W, default 11: width of the counters, timing fields and position outputs.
REQ-003 Parameter SYNC_POL, default 0: active level of hsync and vsync (0 means active-low).
REQ-004 Parameter BAR_SHIFT, default 6: the colour-bar index is x_pos[BAR_SHIFT+2:BAR_SHIFT].
REQ-005 Parameters H_SYNC_D=96, H_BP_D=48, H_ACT_D=640, H_FP_D=16, V_SYNC_D=2, V_BP_D=33, V_ACT_D=480, V_FP_D=10: timing values loaded at reset.
REQ-006 Port clk_in, input, 1 bit: pixel clock.
REQ-007 Port rst_in, input, 1 bit: asynchronous reset, active-high.
REQ-008 Ports h_sync_w, h_bp_w, h_act_w, h_fp_w, input, CNT_W bits each: requested horizontal timing in pixels.
REQ-009 Ports v_sync_w, v_bp_w, v_act_w, v_fp_w, input, CNT_W bits each: requested vertical timing in lines.
REQ-010 Port pixel_in, input, 12 bits: external RGB444 pixel.
REQ-011 Port pattern_sel, input, 2 bits: output colour source.
REQ-012 Port hsync, output, 1 bit: horizontal sync.
REQ-013 Port vsync, output, 1 bit: vertical sync.
REQ-014 Port de, output, 1 bit: data enable, high for active pixels.
REQ-015 Ports x_pos and y_pos, output, CNT_W bits each: active-area coordinates, 0 when de=0.
REQ-016 Port rgb, output, 12 bits: colour, 12'h000 when de=0.
REQ-017 Port line_start, output, 1 bit: one-cycle pulse at the start of each line.
REQ-018 Port frame_start, output, 1 bit: one-cycle pulse at the start of each frame.

Function
REQ-019 Internal counters hc and vc SHALL each be CNT_W+2 bits.
REQ-020 HTOT SHALL equal the sum of the four shadow horizontal fields, computed in CNT_W+2 bits; VTOT SHALL equal the sum of the four shadow vertical fields.
REQ-021 hc SHALL count from 0 to HTOT-1 and then wrap to 0; vc SHALL increment only when hc wraps, and SHALL wrap from VTOT-1 to 0.
REQ-022 Segment order SHALL be sync, then back porch, then active, then front porch: sync when cnt<SYNC; active when SYNC+BP<=cnt<SYNC+BP+ACT.
REQ-023 All outputs SHALL be registered, with a latency of exactly one clock from the hc/vc state they describe.
REQ-024 hsync SHALL equal SYNC_POL while hc is in h-sync, and ~SYNC_POL otherwise; vsync SHALL behave the same way on vc.
REQ-025 de SHALL be 1 only when both hc and vc are in their active segments.
REQ-026 x_pos SHALL be hc-(h_sync+h_bp) and y_pos SHALL be vc-(v_sync+v_bp), taken modulo 2^CNT_W.
REQ-027 line_start SHALL pulse when hc==0; frame_start SHALL pulse when hc==0 and vc==0.
REQ-028 The shadow timing registers SHALL load all eight inputs only on the cycle where hc==HTOT-1 and vc==VTOT-1; mid-frame input changes SHALL have no effect until that point.
REQ-029 If a shadow ACT field is 0, or HTOT (or VTOT) is below 2, the corresponding counter SHALL be held at 0 and de SHALL stay 0 until the next valid load.
REQ-030 The wrap-compare SHALL use >=, so that if a counter is ever at or above its total it returns to 0 on the next clock.

Reset
REQ-031 While rst_in=1: hc=vc=0, shadow registers set to the *_D parameters, hsync=vsync=~SYNC_POL, de=0, x_pos=y_pos=0, rgb=0, line_start=frame_start=0.
REQ-032 Assertion of rst_in SHALL take effect immediately, mid-line included; after deassertion the first clock SHALL present hc=0, vc=0, and frame_start=1 one clock later.

Configuration
REQ-033 With TEST_PATTERN_EN defined, pattern_sel=0 SHALL select pixel_in, 1 SHALL select solid red 12'hF00, 2 SHALL select 8 bars (index 0-7 = FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000), and 3 SHALL select a checkerboard (x_pos[4]^y_pos[4] ? FFF : 000).
REQ-034 With TEST_PATTERN_EN undefined, pattern_sel SHALL be ignored and rgb SHALL be pixel_in gated by de.

Verification
REQ-035 Timing config H 2/1/4/1 and V 1/1/2/1 applied before reset release -> HTOT=8, VTOT=5; hsync low 2 of every 8 clocks; de high 4 clocks on 2 lines per 40-clock frame.
REQ-036 Same config -> x_pos steps 0,1,2,3 and y_pos 0,1 while de=1; line_start every 8 clocks; frame_start every 40 clocks.
REQ-037 Change h_act_w from 4 to 6 mid-frame -> current frame keeps HTOT=8; the next frame_start is followed by HTOT=10.
REQ-038 rst_in pulsed at hc=5 -> outputs at reset values immediately, shadows at 640x480 defaults, and the first frame_start arrives 2 clocks after release.
REQ-039 TEST_PATTERN_EN defined, pattern_sel=2, BAR_SHIFT=6 at default timing -> rgb=FFF for x_pos 0-63, FF0 for 64-127, and 000 for x_pos 448-511.
REQ-040 SYNC_POL=1 and h_act_w=0 loaded -> hsync/vsync idle low, de stuck at 0, rgb=000.
